// File: rtl/bht_update_queue.sv
// Elastic update queue between branch resolution and the perceptron predictor's training port.
// Optional statistics counters are built only when BHT_UPDQ_STATS_EN is defined.
module bht_update_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned VLEN  = 64
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       debug_mode_i,
  input  logic                       res_valid_i,
  input  logic [VLEN-1:0]            res_pc_i,
  input  logic                       res_taken_i,
  input  logic                       res_mispredict_i,
  output logic                       upd_valid_o,
  output logic [VLEN-1:0]            upd_pc_o,
  output logic                       upd_taken_o,
  output logic                       upd_mispredict_o,
  input  logic                       upd_ready_i,
  output logic                       full_o,
  output logic [15:0]                drop_cnt_o,
  output logic [$clog2(DEPTH):0]     high_water_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [VLEN-1:0]  r_pc [DEPTH];
  logic [DEPTH-1:0] r_taken;
  logic [DEPTH-1:0] r_mis;
  logic [AW-1:0]    r_head;
  logic [AW-1:0]    r_tail;
  logic [CW-1:0]    r_count;

  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_head_adv;
  logic [CW-1:0]    w_count_next;

  assign w_full     = (r_count == FULL_CNT);
  assign w_push     = res_valid_i && !debug_mode_i && !flush_i;
  assign w_pop      = (r_count != '0) && upd_ready_i;
  // A push into a full queue without a pop evicts the oldest entry.
  assign w_head_adv = w_pop || (w_push && w_full);

  always_comb begin
    w_count_next = r_count;
    if (flush_i) begin
      w_count_next = '0;
    end else if (w_push && !w_pop && !w_full) begin
      w_count_next = r_count + CW'(1);
    end else if (w_pop && !w_push) begin
      w_count_next = r_count - CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_count <= w_count_next;
      if (w_head_adv) r_head <= r_head + AW'(1);
      if (w_push)     r_tail <= r_tail + AW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) r_pc[i] <= '0;
      r_taken <= '0;
      r_mis   <= '0;
    end else if (w_push) begin
      r_pc[r_tail]    <= res_pc_i;
      r_taken[r_tail] <= res_taken_i;
      r_mis[r_tail]   <= res_mispredict_i;
    end
  end

  assign upd_valid_o      = (r_count != '0);
  assign upd_pc_o         = r_pc[r_head];
  assign upd_taken_o      = r_taken[r_head];
  assign upd_mispredict_o = r_mis[r_head];
  assign full_o           = w_full;

`ifdef BHT_UPDQ_STATS_EN
  logic [15:0]   r_drop_cnt;
  logic [CW-1:0] r_high_water;

  // Stats survive a flush; only reset clears them.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_drop_cnt   <= '0;
      r_high_water <= '0;
    end else begin
      if (w_push && w_full && !w_pop && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 16'd1;
      if (w_count_next > r_high_water) r_high_water <= w_count_next;
    end
  end

  assign drop_cnt_o   = r_drop_cnt;
  assign high_water_o = r_high_water;
`else
  assign drop_cnt_o   = '0;
  assign high_water_o = '0;
`endif

endmodule

// File: tb/tb_bht_update_queue.sv
// Scoreboard bench for bht_update_queue: directed pushes queue expected head entries,
// a negedge monitor checks every accepted update in order.
module tb_bht_update_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned VLEN  = 64;
`ifdef BHT_UPDQ_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct packed {
    logic [VLEN-1:0] pc;
    logic            taken;
    logic            mis;
  } ent_t;

  logic                   clk_i = 1'b0;
  logic                   rst_i;
  logic                   flush_i;
  logic                   debug_mode_i;
  logic                   res_valid_i;
  logic [VLEN-1:0]        res_pc_i;
  logic                   res_taken_i;
  logic                   res_mispredict_i;
  logic                   upd_valid_o;
  logic [VLEN-1:0]        upd_pc_o;
  logic                   upd_taken_o;
  logic                   upd_mispredict_o;
  logic                   upd_ready_i;
  logic                   full_o;
  logic [15:0]            drop_cnt_o;
  logic [$clog2(DEPTH):0] high_water_o;

  int   checks = 0;
  int   errors = 0;
  ent_t expq[$];

  bht_update_queue #(.DEPTH(DEPTH), .VLEN(VLEN)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .debug_mode_i(debug_mode_i),
    .res_valid_i(res_valid_i), .res_pc_i(res_pc_i), .res_taken_i(res_taken_i),
    .res_mispredict_i(res_mispredict_i), .upd_valid_o(upd_valid_o), .upd_pc_o(upd_pc_o),
    .upd_taken_o(upd_taken_o), .upd_mispredict_o(upd_mispredict_o), .upd_ready_i(upd_ready_i),
    .full_o(full_o), .drop_cnt_o(drop_cnt_o), .high_water_o(high_water_o)
  );

  always #5 clk_i = ~clk_i;

  // Every accepted head entry must match the oldest expected entry.
  always @(negedge clk_i) begin
    if (!rst_i && upd_valid_o && upd_ready_i) begin
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_update: got pc=%h taken=%b mis=%b, none expected",
                 upd_pc_o, upd_taken_o, upd_mispredict_o);
      end else begin
        ent_t e;
        e = expq.pop_front();
        if ({upd_pc_o, upd_taken_o, upd_mispredict_o} !== e) begin
          errors++;
          $display("[TB] FAIL update_order: got pc=%h taken=%b mis=%b, expected pc=%h taken=%b mis=%b",
                   upd_pc_o, upd_taken_o, upd_mispredict_o, e.pc, e.taken, e.mis);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Drives one cycle of resolution input and predictor ready, then drops the push.
  task automatic applyStimulus(input logic valid, input logic [VLEN-1:0] pc, input logic taken,
                               input logic mis, input logic ready);
    res_valid_i      = valid;
    res_pc_i         = pc;
    res_taken_i      = taken;
    res_mispredict_i = mis;
    upd_ready_i      = ready;
    tick();
    res_valid_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; flush_i = 1'b0; debug_mode_i = 1'b0; res_valid_i = 1'b0;
    res_pc_i = '0; res_taken_i = 1'b0; res_mispredict_i = 1'b0; upd_ready_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;

    checkOutput("reset_pc", upd_pc_o, 64'h0);
    checkOutput("reset_hw", 64'(high_water_o), 64'h0);
    for (int i = 0; i < 10; i++) begin
      checkOutput("idle_valid", 64'(upd_valid_o), 64'h0);
      checkOutput("idle_full", 64'(full_o), 64'h0);
      checkOutput("idle_drop", 64'(drop_cnt_o), 64'h0);
      tick();
    end

    // Single push with ready high: visible next cycle, gone the one after.
    expq.push_back('{pc: 64'h8000_0010, taken: 1'b1, mis: 1'b0});
    applyStimulus(1'b1, 64'h8000_0010, 1'b1, 1'b0, 1'b1);
    checkOutput("single_valid", 64'(upd_valid_o), 64'h1);
    checkOutput("single_pc", upd_pc_o, 64'h8000_0010);
    checkOutput("single_taken", 64'(upd_taken_o), 64'h1);
    tick();
    checkOutput("single_empty", 64'(upd_valid_o), 64'h0);

    // Fill to DEPTH, then overflow: 0x100 is evicted.
    applyStimulus(1'b1, 64'h100, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 64'h104, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 64'h108, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 64'h10C, 1'b1, 1'b1, 1'b0);
    checkOutput("fill_full", 64'(full_o), 64'h1);
    checkOutput("fill_hw", 64'(high_water_o), STATS ? 64'h4 : 64'h0);
    checkOutput("fill_drop", 64'(drop_cnt_o), 64'h0);
    checkOutput("fill_head_pc", upd_pc_o, 64'h100);
    applyStimulus(1'b1, 64'h110, 1'b0, 1'b0, 1'b0);
    checkOutput("ovf_drop", 64'(drop_cnt_o), STATS ? 64'h1 : 64'h0);
    checkOutput("ovf_full", 64'(full_o), 64'h1);
    checkOutput("ovf_head_pc", upd_pc_o, 64'h104);
    expq.push_back('{pc: 64'h104, taken: 1'b1, mis: 1'b0});
    expq.push_back('{pc: 64'h108, taken: 1'b0, mis: 1'b1});
    expq.push_back('{pc: 64'h10C, taken: 1'b1, mis: 1'b1});
    expq.push_back('{pc: 64'h110, taken: 1'b0, mis: 1'b0});
    upd_ready_i = 1'b1;
    repeat (4) tick();
    checkOutput("ovf_drained_valid", 64'(upd_valid_o), 64'h0);
    checkOutput("ovf_drained_full", 64'(full_o), 64'h0);
    checkOutput("ovf_scoreboard_empty", 64'(expq.size()), 64'h0);

    // Full queue with simultaneous push and pop: no drop, stays full.
    upd_ready_i = 1'b0;
    applyStimulus(1'b1, 64'h200, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 64'h204, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 64'h208, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 64'h20C, 1'b1, 1'b0, 1'b0);
    expq.push_back('{pc: 64'h200, taken: 1'b0, mis: 1'b0});
    expq.push_back('{pc: 64'h204, taken: 1'b1, mis: 1'b0});
    expq.push_back('{pc: 64'h208, taken: 1'b0, mis: 1'b0});
    expq.push_back('{pc: 64'h20C, taken: 1'b1, mis: 1'b0});
    expq.push_back('{pc: 64'h210, taken: 1'b0, mis: 1'b1});
    applyStimulus(1'b1, 64'h210, 1'b0, 1'b1, 1'b1);
    checkOutput("pushpop_full", 64'(full_o), 64'h1);
    checkOutput("pushpop_drop", 64'(drop_cnt_o), STATS ? 64'h1 : 64'h0);
    checkOutput("pushpop_head_pc", upd_pc_o, 64'h204);
    repeat (4) tick();
    checkOutput("pushpop_drained", 64'(upd_valid_o), 64'h0);
    checkOutput("pushpop_scoreboard_empty", 64'(expq.size()), 64'h0);

    // Flush with a concurrent push: everything, including that push, vanishes.
    applyStimulus(1'b1, 64'h300, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 64'h304, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 64'h308, 1'b0, 1'b0, 1'b0);
    flush_i = 1'b1;
    applyStimulus(1'b1, 64'h30C, 1'b1, 1'b1, 1'b0);
    flush_i = 1'b0;
    checkOutput("flush_valid", 64'(upd_valid_o), 64'h0);
    checkOutput("flush_full", 64'(full_o), 64'h0);
    checkOutput("flush_hw_kept", 64'(high_water_o), STATS ? 64'h4 : 64'h0);
    expq.push_back('{pc: 64'h400, taken: 1'b1, mis: 1'b0});
    applyStimulus(1'b1, 64'h400, 1'b1, 1'b0, 1'b1);
    checkOutput("flush_sentinel_pc", upd_pc_o, 64'h400);
    tick();
    checkOutput("flush_sentinel_gone", 64'(upd_valid_o), 64'h0);

    // Debug mode suppresses pushes.
    debug_mode_i = 1'b1;
    applyStimulus(1'b1, 64'h500, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 64'h504, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 64'h508, 1'b1, 1'b0, 1'b0);
    debug_mode_i = 1'b0;
    checkOutput("debug_valid", 64'(upd_valid_o), 64'h0);
    checkOutput("debug_full", 64'(full_o), 64'h0);
    checkOutput("final_drop", 64'(drop_cnt_o), STATS ? 64'h1 : 64'h0);
    checkOutput("final_scoreboard_empty", 64'(expq.size()), 64'h0);

    // Asynchronous reset between clock edges clears state at once.
    applyStimulus(1'b1, 64'h600, 1'b1, 1'b1, 1'b0);
    checkOutput("pre_areset_valid", 64'(upd_valid_o), 64'h1);
    #2 rst_i = 1'b1;
    #1;
    checkOutput("areset_valid", 64'(upd_valid_o), 64'h0);
    checkOutput("areset_pc", upd_pc_o, 64'h0);
    checkOutput("areset_drop", 64'(drop_cnt_o), 64'h0);
    checkOutput("areset_hw", 64'(high_water_o), 64'h0);
    tick();
    rst_i = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
